// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive lamp-legality, phase-order and dwell checker
// Decodes the six lamp lines back into a phase and flags any deviation from the controller's schedule.
module traffic_light_monitor #(
  parameter int unsigned GREEN_TICKS  = 5,
  parameter int unsigned YELLOW_TICKS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        ns_g_i,
  input  logic        ns_y_i,
  input  logic        ns_r_i,
  input  logic        ew_g_i,
  input  logic        ew_y_i,
  input  logic        ew_r_i,
  output logic [1:0]  phase_o,
  output logic        phase_valid_o,
  output logic        locked_o,
  output logic [7:0]  dwell_o,
  output logic [15:0] cycles_o,
  output logic        err_onehot_o,
  output logic        err_conflict_o,
  output logic        err_seq_o,
  output logic        err_dur_o,
  output logic        err_any_o
);

  typedef enum logic [1:0] {
    NS_G = 2'b00,
    NS_Y = 2'b01,
    EW_G = 2'b10,
    EW_Y = 2'b11
  } phase_e;

  localparam logic [7:0] GREEN_REQ  = 8'(GREEN_TICKS);
  localparam logic [7:0] YELLOW_REQ = 8'(YELLOW_TICKS);

  phase_e      phase_q;
  logic        tick_q;
  logic        phase_valid_q;
  logic        locked_q;
  logic [7:0]  dwell_q;
  logic [15:0] cycles_q;
  logic        err_onehot_q;
  logic        err_conflict_q;
  logic        err_seq_q;
  logic        err_dur_q;
  logic        err_any_q;

  logic        tick_ev;
  logic [1:0]  ns_cnt;
  logic [1:0]  ew_cnt;
  logic        bad_onehot;
  logic        conflict;
  logic        all_red;
  logic        legal;
  phase_e      lamp_phase;
  logic        change;
  logic        successor;
  logic [7:0]  dwell_d;
  logic [7:0]  req;

  always_comb begin
    tick_ev    = tick_i & ~tick_q;
    ns_cnt     = {1'b0, ns_g_i} + {1'b0, ns_y_i} + {1'b0, ns_r_i};
    ew_cnt     = {1'b0, ew_g_i} + {1'b0, ew_y_i} + {1'b0, ew_r_i};
    bad_onehot = (ns_cnt != 2'd1) || (ew_cnt != 2'd1);
    conflict   = !bad_onehot && !ns_r_i && !ew_r_i;
    all_red    = !bad_onehot && ns_r_i && ew_r_i;
    legal      = !bad_onehot && !conflict && !all_red;

    // Only meaningful when legal: exactly one direction is non-red.
    lamp_phase = NS_G;
    if (ns_y_i)      lamp_phase = NS_Y;
    else if (ew_g_i) lamp_phase = EW_G;
    else if (ew_y_i) lamp_phase = EW_Y;

    change    = legal && (lamp_phase != phase_q);
    successor = (lamp_phase == phase_e'(phase_q + 2'd1));
    dwell_d   = (tick_ev && dwell_q != 8'hFF) ? dwell_q + 8'd1 : dwell_q;
    req       = phase_q[0] ? YELLOW_REQ : GREEN_REQ;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q        <= NS_G;
      tick_q         <= 1'b0;
      phase_valid_q  <= 1'b0;
      locked_q       <= 1'b0;
      dwell_q        <= 8'd0;
      cycles_q       <= 16'd0;
      err_onehot_q   <= 1'b0;
      err_conflict_q <= 1'b0;
      err_seq_q      <= 1'b0;
      err_dur_q      <= 1'b0;
      err_any_q      <= 1'b0;
    end else begin
      tick_q        <= tick_i;
      phase_valid_q <= legal;
      err_any_q     <= err_onehot_q | err_conflict_q | err_seq_q | err_dur_q;

      if (bad_onehot) err_onehot_q   <= 1'b1;
      if (conflict)   err_conflict_q <= 1'b1;

      if (change) begin
        // A tick in the change cycle belongs to the phase being left.
        phase_q <= lamp_phase;
        dwell_q <= 8'd0;
        if (successor) begin
          if (locked_q && dwell_d != req) begin
            err_dur_q <= 1'b1;
            locked_q  <= 1'b0;
          end else begin
            locked_q  <= 1'b1;
          end
          if (phase_q == EW_Y && locked_q) cycles_q <= cycles_q + 16'd1;
        end else begin
          if (locked_q) err_seq_q <= 1'b1;
          locked_q <= 1'b0;
        end
      end else begin
        dwell_q <= dwell_d;
        // Stuck phase: fires once, since it drops the lock it depends on.
        if (legal && locked_q && tick_ev && dwell_d > req) begin
          err_dur_q <= 1'b1;
          locked_q  <= 1'b0;
        end
        if (all_red && locked_q) begin
          err_seq_q <= 1'b1;
          locked_q  <= 1'b0;
        end
      end
    end
  end

  assign phase_o        = phase_q;
  assign phase_valid_o  = phase_valid_q;
  assign locked_o       = locked_q;
  assign dwell_o        = dwell_q;
  assign cycles_o       = cycles_q;
  assign err_onehot_o   = err_onehot_q;
  assign err_conflict_o = err_conflict_q;
  assign err_seq_o      = err_seq_q;
  assign err_dur_o      = err_dur_q;
  assign err_any_o      = err_any_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed self-checking bench for traffic_light_monitor
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_light_monitor;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;
  logic [1:0]  phase;
  logic        phase_valid;
  logic        locked;
  logic [7:0]  dwell;
  logic [15:0] cycles;
  logic        err_onehot, err_conflict, err_seq, err_dur, err_any;

  int n_checks;
  int n_fail;

  traffic_light_monitor #(
    .GREEN_TICKS  (5),
    .YELLOW_TICKS (2)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .tick_i         (tick),
    .ns_g_i         (ns_g),
    .ns_y_i         (ns_y),
    .ns_r_i         (ns_r),
    .ew_g_i         (ew_g),
    .ew_y_i         (ew_y),
    .ew_r_i         (ew_r),
    .phase_o        (phase),
    .phase_valid_o  (phase_valid),
    .locked_o       (locked),
    .dwell_o        (dwell),
    .cycles_o       (cycles),
    .err_onehot_o   (err_onehot),
    .err_conflict_o (err_conflict),
    .err_seq_o      (err_seq),
    .err_dur_o      (err_dur),
    .err_any_o      (err_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic raw(input logic [5:0] v);
    {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r} = v;
  endtask

  task automatic lamps(input logic [1:0] p);
    case (p)
      2'b00:   raw(6'b100_001);
      2'b01:   raw(6'b010_001);
      2'b10:   raw(6'b001_100);
      default: raw(6'b001_010);
    endcase
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc();
    cyc();
    tick = 1'b0;
    cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic run(input logic [1:0] p, input int n);
    lamps(p);
    cyc();
    ticks(n);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    lamps(2'b00);
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_phase"},  16'(phase), 16'h0);
    chk({tag, "_valid"},  16'(phase_valid), 16'h0);
    chk({tag, "_locked"}, 16'(locked), 16'h0);
    chk({tag, "_dwell"},  16'(dwell), 16'h0);
    chk({tag, "_cycles"}, cycles, 16'h0);
    chk({tag, "_errs"},   16'({err_onehot, err_conflict, err_seq, err_dur}), 16'h0);
    chk({tag, "_errany"}, 16'(err_any), 16'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    tick = 1'b0;
    lamps(2'b00);
    cyc();
    cyc();
    chk_reset_values("reset");
    rst = 1'b0;
    cyc();
    chk("first_valid", 16'(phase_valid), 16'h1);

    // nominal run, first phase unchecked
    ticks(5);
    chk("nom_ns_g_dwell", 16'(dwell), 16'd5);
    chk("nom_unlocked", 16'(locked), 16'h0);
    lamps(2'b01);
    cyc();
    chk("nom_lock", 16'(locked), 16'h1);
    chk("nom_phase_nsy", 16'(phase), 16'h1);
    ticks(2);
    chk("nom_ns_y_dwell", 16'(dwell), 16'd2);
    run(2'b10, 5);
    chk("nom_ew_g_dwell", 16'(dwell), 16'd5);
    run(2'b11, 2);
    lamps(2'b00);
    cyc();
    chk("nom_cycles1", cycles, 16'd1);
    chk("nom_phase_nsg", 16'(phase), 16'h0);
    ticks(5);
    run(2'b01, 2);
    run(2'b10, 5);
    run(2'b11, 2);
    lamps(2'b00);
    cyc();
    chk("nom_cycles2", cycles, 16'd2);
    chk("nom_no_err", 16'({err_onehot, err_conflict, err_seq, err_dur, err_any}), 16'h0);
    chk("nom_locked", 16'(locked), 16'h1);

    // short green
    ticks(4);
    lamps(2'b01);
    cyc();
    chk("short_err_dur", 16'(err_dur), 16'h1);
    chk("short_unlock", 16'(locked), 16'h0);
    chk("short_errany_lag", 16'(err_any), 16'h0);
    cyc();
    chk("short_errany", 16'(err_any), 16'h1);
    ticks(2);
    lamps(2'b10);
    cyc();
    chk("short_relock", 16'(locked), 16'h1);
    chk("short_cycles", cycles, 16'd2);

    // conflict
    reset_dut();
    lamps(2'b01);
    cyc();
    chk("cf_locked_pre", 16'(locked), 16'h1);
    raw(6'b100_100);
    cyc();
    chk("cf_flag", 16'(err_conflict), 16'h1);
    chk("cf_errany_lag", 16'(err_any), 16'h0);
    chk("cf_phase", 16'(phase), 16'h1);
    chk("cf_valid", 16'(phase_valid), 16'h0);
    chk("cf_locked", 16'(locked), 16'h1);
    lamps(2'b01);
    cyc();
    chk("cf_errany", 16'(err_any), 16'h1);
    chk("cf_valid_back", 16'(phase_valid), 16'h1);
    chk("cf_no_onehot", 16'(err_onehot), 16'h0);

    // bad one-hot, tick in the same cycle still counted
    raw(6'b110_001);
    tick = 1'b1;
    cyc();
    chk("oh_flag", 16'(err_onehot), 16'h1);
    chk("oh_locked", 16'(locked), 16'h1);
    chk("oh_phase", 16'(phase), 16'h1);
    chk("oh_dwell", 16'(dwell), 16'd1);
    tick = 1'b0;
    lamps(2'b01);
    cyc();

    // tick event coincident with a legal change
    tick = 1'b1;
    lamps(2'b10);
    cyc();
    chk("sim_no_dur", 16'(err_dur), 16'h0);
    chk("sim_dwell", 16'(dwell), 16'd0);
    chk("sim_phase", 16'(phase), 16'h2);
    chk("sim_locked", 16'(locked), 16'h1);
    tick = 1'b0;
    cyc();

    // skip EW_G -> NS_G
    lamps(2'b00);
    cyc();
    chk("skip_err_seq", 16'(err_seq), 16'h1);
    chk("skip_unlock", 16'(locked), 16'h0);
    chk("skip_cycles", cycles, 16'd0);
    chk("skip_phase", 16'(phase), 16'h0);

    // all-red while locked
    reset_dut();
    lamps(2'b01);
    cyc();
    raw(6'b001_001);
    cyc();
    chk("ar_err_seq", 16'(err_seq), 16'h1);
    chk("ar_unlock", 16'(locked), 16'h0);
    chk("ar_phase", 16'(phase), 16'h1);

    // stuck yellow, then reset
    reset_dut();
    run(2'b01, 2);
    run(2'b10, 5);
    run(2'b11, 2);
    chk("stuck_pre_dur", 16'(err_dur), 16'h0);
    chk("stuck_pre_dwell", 16'(dwell), 16'd2);
    chk("stuck_pre_locked", 16'(locked), 16'h1);
    tick = 1'b1;
    cyc();
    chk("stuck_err_dur", 16'(err_dur), 16'h1);
    chk("stuck_unlock", 16'(locked), 16'h0);
    chk("stuck_dwell", 16'(dwell), 16'd3);
    tick = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    chk_reset_values("rst_mid");
    rst = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker sitting on the lamp outputs of the traffic-light controller. It shares the controller's `clk`, `rst` and `tick` and decodes the six lamp lines back into a phase. It checks lamp legality, phase order and per-phase dwell time in ticks, and reports sticky error flags plus progress counters for the bench and for on-chip debug. It drives nothing back into the controller.

## Interface
- `GREEN_TICKS`, 5, required dwell of NS_G and EW_G phases, in tick events (1..255)
- `YELLOW_TICKS`, 2, required dwell of NS_Y and EW_Y phases, in tick events (1..255)
- `clk` in 1: system clock; all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `tick` in 1: 1 Hz timebase level (multi-cycle high); only its rising edge is used
- `ns_g`, `ns_y`, `ns_r` in 1 each: north-south lamps
- `ew_g`, `ew_y`, `ew_r` in 1 each: east-west lamps
- `phase` out 2: last legal phase; 00 NS_G, 01 NS_Y, 10 EW_G, 11 EW_Y
- `phase_valid` out 1: current-cycle lamps form a legal phase
- `locked` out 1: at least one legal transition seen since reset or since the last seq/dur error
- `dwell` out 8: tick events counted in the current phase, saturating at 255
- `cycles` out 16: completed EW_Y→NS_G transitions while locked, wrapping
- `err_onehot`, `err_conflict`, `err_seq`, `err_dur` out 1 each: sticky error flags
- `err_any` out 1: OR of the four error flags, registered

## Operation
- **Tick event:** `tick`=1 and `tick_q`=0, where `tick_q` is `tick` registered. `tick_q` resets to 0.
- **Lamp decode**, evaluated every cycle after reset:
  - Any direction with other than exactly one lamp on sets `err_onehot`.
  - Else, both directions non-red sets `err_conflict`.
  - Else, all-red is not a phase: sets `err_seq` if `locked`, otherwise it is ignored.
  - Else the lamps form a legal phase: NS_G = ns_g & ew_r; NS_Y = ns_y & ew_r; EW_G = ns_r & ew_g; EW_Y = ns_r & ew_y.
- **Phase change:** a legal phase different from the registered `phase`.
  - **Legal successor** (NS_G→NS_Y→EW_G→EW_Y→NS_G):
    - If `locked`, compare `dwell` plus 1-if-tick-event-this-cycle against the required dwell of the old phase. A mismatch sets `err_dur`.
    - Set `locked`=1.
    - If the change is EW_Y→NS_G and `locked` was already 1, increment `cycles`.
  - **Any other change:** set `err_seq` if `locked`, then clear `locked`.
  - On every phase change, `phase` takes the new value and `dwell` restarts at 0. A tick event in the same cycle is credited to the old phase.
- **No phase change:** each tick event increments `dwell`, saturating.
  - If `locked` and the incremented value exceeds the phase's required dwell, set `err_dur` and clear `locked`. This is the stuck-phase check; it fires once per lock.
- **Error cycles:** illegal-lamp cycles do not alter `phase` or `dwell`. Tick events in those cycles are still counted into `dwell`.
- **First phase after reset:** never dwell-checked, because `locked`=0 on entry.
- **Lock loss:** `err_seq` and `err_dur` clear `locked`. `err_onehot` and `err_conflict` do not.
- **Error flags:** stay set until `rst`.

## Timing
- **Reset values:** `phase`=00, `phase_valid`=0, `locked`=0, `dwell`=0, `cycles`=0, all `err_*`=0, `err_any`=0.
- **Reset mid-operation:** all state returns to the reset values on the next edge. Lamps are ignored while `rst`=1.
- **Latency:** all outputs are registered. An error condition present in cycle t appears on its flag at edge t+1 and on `err_any` at edge t+2. `phase`, `dwell`, `locked` and `cycles` update at edge t+1.
- **`phase_valid`:** registered decode of cycle t, so it also lags by 1.
- **Simultaneous events:**
  - Tick event plus phase change: tick credited to the old phase, new `dwell`=0.
  - Multiple errors in one cycle: all applicable flags set.
- **Wrap and saturation:** `cycles` wraps 0xFFFF→0. `dwell` saturates at 255.

## Test plan
- **Nominal run** (defaults, compliant controller, 40 ticks): `locked`=1 after the first transition; `cycles` increments by 1 every 14 ticks; all `err_*`=0; `dwell` peaks at 5 in green phases and 2 in yellow.
- **Short green** (NS_G held 4 ticks while locked, then NS_Y): `err_dur`=1 one cycle after the change; `locked` drops, then returns at the next legal transition.
- **Conflict** (force ns_g=1, ew_g=1 for one cycle): `err_conflict`=1 at the next edge; `err_any`=1 one edge later; `phase` unchanged.
- **Bad one-hot** (ns_g=ns_y=1 for one cycle): `err_onehot`=1; `locked` unchanged.
- **Skip** (EW_G→NS_G while locked): `err_seq`=1, `locked`=0, `cycles` not incremented.
- **Stuck and reset** (hold EW_Y for 3 ticks while locked, then pulse `rst`): `err_dur`=1 at the edge after the third tick event; after `rst`, all outputs return to their reset values.
